upsample: RTL and testbench



---
 rtl/mnist_pkg.sv | 20 ++
 rtl/feature_if.sv | 14 +
 rtl/upsample_row_buf.sv | 33 +++
 rtl/upsample.sv | 127 ++++++++++++
 tb/tb_upsample.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// Shared types for the MNIST feature pipeline: feature element type, lane
// count of feature_if, the upsampler state encoding and a width helper.
package mnist_pkg;

  localparam int FEATURE_WIDTH = 8;
  localparam int NUM_FEATURES  = 1;

  typedef logic [FEATURE_WIDTH-1:0] feature_type;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } upsample_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_if.sv
// Valid/ready feature stream. A transfer happens on a rising clock edge
// with valid && ready; features[] carries NUM_FEATURES lanes.
interface feature_if #(
  parameter int N = mnist_pkg::NUM_FEATURES
);

  logic                  valid;
  logic                  ready;
  mnist_pkg::feature_type features [N];

  modport source (output valid, output features, input ready);
  modport sink   (input valid, input features, output ready);

endinterface

// File: rtl/upsample_row_buf.sv
// One-row feature store for the upsampler: single write port, combinational
// read port, cleared by reset.
module upsample_row_buf
  import mnist_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  feature_type   wdata,
  input  logic [AW-1:0] raddr,
  output feature_type   rdata
);

  feature_type mem [DEPTH];

  // Row storage: written one element per accepted input.
  // NOTE: this store is only a handful of registers, so it is reset like any
  // other flop; a real RAM macro could not be cleared this way.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/upsample.sv
// Nearest-neighbour upsampler. Buffers one reduced input row, then replays
// it COL_STRIDE times per element and ROW_STRIDE times per row.
// Optional macro UPSAMPLE_ZERO_INSERT_EN: emit the stored element only at
// the first replica of each block (rep_r == 0, rep_c == 0), zero elsewhere.
module upsample
  import mnist_pkg::*;
#(
  parameter int ROW_STRIDE   = 2,
  parameter int COL_STRIDE   = 2,
  parameter int IMAGE_HEIGHT = 4,
  parameter int IMAGE_WIDTH  = 4
) (
  input logic       clock,
  input logic       reset_n,
  feature_if.sink   features_in,
  feature_if.source features_out
);

  localparam int IN_H  = IMAGE_HEIGHT / ROW_STRIDE;
  localparam int IN_W  = IMAGE_WIDTH / COL_STRIDE;
  localparam int COL_W = cnt_bits(IN_W);
  localparam int ROW_W = cnt_bits(IN_H);
  localparam int RC_W  = cnt_bits(COL_STRIDE);
  localparam int RR_W  = cnt_bits(ROW_STRIDE);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(COL_STRIDE - 1);
  localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(ROW_STRIDE - 1);

  if (ROW_STRIDE < 1 || COL_STRIDE < 1) begin : g_bad_stride
    $error("upsample: strides must be >= 1");
  end
  if (IMAGE_HEIGHT % ROW_STRIDE != 0) begin : g_bad_height
    $error("upsample: IMAGE_HEIGHT not divisible by ROW_STRIDE");
  end
  if (IMAGE_WIDTH % COL_STRIDE != 0) begin : g_bad_width
    $error("upsample: IMAGE_WIDTH not divisible by COL_STRIDE");
  end

  upsample_state_t   state;
  logic [COL_W-1:0]  in_col;
  logic [COL_W-1:0]  buf_col;
  logic [RC_W-1:0]   rep_c;
  logic [RR_W-1:0]   rep_r;
  logic [ROW_W-1:0]  in_row;
  feature_type       buf_rdata;

  upsample_row_buf #(
    .DEPTH (IN_W),
    .AW    (COL_W)
  ) u_row_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (state == LOAD && features_in.valid),
    .waddr   (in_col),
    .wdata   (features_in.features[0]),
    .raddr   (buf_col),
    .rdata   (buf_rdata)
  );

  // Row fill in LOAD, replication counters in EMIT; position lives only here.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LOAD;
      in_col  <= '0;
      buf_col <= '0;
      rep_c   <= '0;
      rep_r   <= '0;
      in_row  <= '0;
    end else begin
      assert (in_row <= ROW_LAST);
      unique case (state)
        LOAD: begin
          if (features_in.valid) begin
            if (in_col == COL_LAST) begin
              in_col <= '0;
              state  <= EMIT;
            end else begin
              in_col <= in_col + 1'b1;
            end
          end
        end
        EMIT: begin
          if (features_out.ready) begin
            if (rep_c == RC_LAST) begin
              rep_c <= '0;
              if (buf_col == COL_LAST) begin
                buf_col <= '0;
                if (rep_r == RR_LAST) begin
                  rep_r  <= '0;
                  in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                  state  <= LOAD;
                end else begin
                  rep_r <= rep_r + 1'b1;
                end
              end else begin
                buf_col <= buf_col + 1'b1;
              end
            end else begin
              rep_c <= rep_c + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Handshake and data decoded from state only, never from output ready.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    features_in.ready  = (state == LOAD);
    features_out.valid = (state == EMIT);
    for (int i = 0; i < NUM_FEATURES; i++) features_out.features[i] = '0;
    if (state == EMIT) begin
`ifdef UPSAMPLE_ZERO_INSERT_EN
      if (rep_r == '0 && rep_c == '0) features_out.features[0] = buf_rdata;
`else
      features_out.features[0] = buf_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_upsample.sv
// Directed bench for upsample with default parameters (4x4 out, 2x2 strides).
// Expected streams follow UPSAMPLE_ZERO_INSERT_EN when the bench is built
// with that macro defined.
module tb_upsample;
  import mnist_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  feature_if in_if ();
  feature_if out_if ();

  upsample #(
    .ROW_STRIDE   (2),
    .COL_STRIDE   (2),
    .IMAGE_HEIGHT (4),
    .IMAGE_WIDTH  (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .features_in  (in_if),
    .features_out (out_if)
  );

`ifdef UPSAMPLE_ZERO_INSERT_EN
  localparam feature_type EXP_A [16] = '{1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0};
  localparam feature_type EXP_B [16] = '{5,0,6,0,0,0,0,0,7,0,8,0,0,0,0,0};
  localparam feature_type EXP_C [16] = '{4,0,3,0,0,0,0,0,2,0,1,0,0,0,0,0};
  localparam feature_type EXP_9 [16] = '{1,0,2,0,0,0,0,0,9,0,4,0,0,0,0,0};
`else
  localparam feature_type EXP_A [16] = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
  localparam feature_type EXP_B [16] = '{5,5,6,6,5,5,6,6,7,7,8,8,7,7,8,8};
  localparam feature_type EXP_C [16] = '{4,4,3,3,4,4,3,3,2,2,1,1,2,2,1,1};
  localparam feature_type EXP_9 [16] = '{1,1,2,2,1,1,2,2,9,9,4,4,9,9,4,4};
`endif

  int checks = 0;
  int errors = 0;

  feature_type in_q [$];
  feature_type out_q [$];
  feature_type stall_vals [$];
  int          accept_cycles [$];
  int          first_valid_cycle;
  int          iters;
  int          emit_blocked;
  int          overlap;
  bit          timed_out;

  // Producer/consumer loop: drives at negedge, records what transfers at the
  // following posedge. Output ready drops for stall_len cycles while output
  // index stall_at is presented.
  task automatic run_stream(input int n_out, input int stall_at, input int stall_len);
    int stall_left = stall_len;
    int cyc = 0;
    out_q.delete();
    stall_vals.delete();
    accept_cycles.delete();
    first_valid_cycle = -1;
    emit_blocked = 0;
    overlap = 0;
    timed_out = 1'b0;
    while (out_q.size() < n_out) begin
      if (cyc >= 2000) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clock);
      in_if.valid = (in_q.size() > 0);
      in_if.features[0] = (in_q.size() > 0) ? in_q[0] : '0;
      #1;
      if (out_if.valid && first_valid_cycle < 0) first_valid_cycle = cyc;
      if (out_if.valid && out_q.size() == stall_at && stall_left > 0) begin
        out_if.ready = 1'b0;
        stall_left--;
        stall_vals.push_back(out_if.features[0]);
      end else begin
        out_if.ready = 1'b1;
      end
      if (in_if.valid && !in_if.ready) emit_blocked++;
      if (in_if.ready && out_if.valid) overlap++;
      if (in_if.valid && in_if.ready) begin
        void'(in_q.pop_front());
        accept_cycles.push_back(cyc);
      end
      if (out_if.valid && out_if.ready) out_q.push_back(out_if.features[0]);
      cyc++;
      @(posedge clock);
    end
    iters = cyc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_if.valid = 1'b0;
    in_if.features[0] = '0;
    out_if.ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_if.ready);
    end
    checks++;
    if (out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_if.valid);
    end
    checks++;
    if (out_if.features[0] !== 8'd0) begin
      errors++;
      $display("FAIL reset_out_data: got %0d expected 0", out_if.features[0]);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_replicate();
    feature_type got;
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_stream(16, -1, 0);
    checks++;
    if (timed_out || out_q.size() != 16) begin
      errors++;
      $display("FAIL replicate_count: got %0d outputs (timeout %0b) expected 16", out_q.size(), timed_out);
    end
    for (int i = 0; i < 16; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      checks++;
      if (got !== EXP_A[i]) begin
        errors++;
        $display("FAIL replicate_out[%0d]: got %0d expected %0d", i, got, EXP_A[i]);
      end
    end
    checks++;
    if (accept_cycles.size() < 2 || first_valid_cycle - accept_cycles[1] != 1) begin
      errors++;
      $display("FAIL replicate_latency: first valid cycle %0d, accepts %0d, expected 1 cycle after second accept",
               first_valid_cycle, accept_cycles.size());
    end
  endtask

  task automatic test_backpressure();
    feature_type got;
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_stream(16, 5, 3);
    checks++;
    if (timed_out || out_q.size() != 16) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs (timeout %0b) expected 16", out_q.size(), timed_out);
    end
    for (int i = 0; i < 16; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      checks++;
      if (got !== EXP_A[i]) begin
        errors++;
        $display("FAIL stall_out[%0d]: got %0d expected %0d", i, got, EXP_A[i]);
      end
    end
    checks++;
    if (stall_vals.size() != 3) begin
      errors++;
      $display("FAIL stall_valid_held: got %0d valid stall cycles expected 3", stall_vals.size());
    end
    foreach (stall_vals[i]) begin
      checks++;
      if (stall_vals[i] !== EXP_A[5]) begin
        errors++;
        $display("FAIL stall_data_held[%0d]: got %0d expected %0d", i, stall_vals[i], EXP_A[5]);
      end
    end
  endtask

  task automatic test_input_hold();
    feature_type got;
    in_q = '{8'd1, 8'd2, 8'd9, 8'd4};
    run_stream(16, -1, 0);
    checks++;
    if (timed_out || out_q.size() != 16) begin
      errors++;
      $display("FAIL hold_count: got %0d outputs (timeout %0b) expected 16", out_q.size(), timed_out);
    end
    for (int i = 0; i < 16; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      checks++;
      if (got !== EXP_9[i]) begin
        errors++;
        $display("FAIL hold_out[%0d]: got %0d expected %0d", i, got, EXP_9[i]);
      end
    end
    checks++;
    if (emit_blocked != 8) begin
      errors++;
      $display("FAIL hold_blocked_cycles: got %0d expected 8", emit_blocked);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL hold_ready_during_emit: got %0d cycles expected 0", overlap);
    end
  endtask

  task automatic test_back_to_back();
    feature_type got;
    feature_type exp;
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_stream(32, -1, 0);
    checks++;
    if (timed_out || out_q.size() != 32) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs (timeout %0b) expected 32", out_q.size(), timed_out);
    end
    for (int i = 0; i < 32; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      exp = (i < 16) ? EXP_A[i] : EXP_B[i-16];
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, got, exp);
      end
    end
    checks++;
    if (iters != 40) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d expected 40", iters);
    end
  endtask

  task automatic test_reset_mid_frame();
    feature_type got;
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_stream(7, -1, 0);
    checks++;
    if (timed_out || out_q.size() != 7) begin
      errors++;
      $display("FAIL midrst_prefix_count: got %0d expected 7", out_q.size());
    end
    @(negedge clock);
    reset_n = 1'b0;
    in_if.valid = 1'b0;
    in_q.delete();
    #1;
    checks++;
    if (out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out_valid: got %b expected 0", out_if.valid);
    end
    checks++;
    if (in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_ready: got %b expected 1", in_if.ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    in_q = '{8'd4, 8'd3, 8'd2, 8'd1};
    run_stream(16, -1, 0);
    checks++;
    if (timed_out || out_q.size() != 16) begin
      errors++;
      $display("FAIL midrst_count: got %0d outputs (timeout %0b) expected 16", out_q.size(), timed_out);
    end
    for (int i = 0; i < 16; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      checks++;
      if (got !== EXP_C[i]) begin
        errors++;
        $display("FAIL midrst_out[%0d]: got %0d expected %0d", i, got, EXP_C[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_replicate();
    test_backpressure();
    test_input_hold();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
